// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Pure declarations: no latency, no flow control.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grants are combinational (0 cycles) and only go to valid requesters.
// A losing requester is held off by its low grant until the priority pointer reaches it.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic gnt0,
  output logic gnt1
);

  arb_state_t state_q, state_d;

  always_comb begin
    gnt0    = req0_valid && (!req1_valid || (state_q == PRI0));
    gnt1    = req1_valid && !gnt0;
    state_d = state_q;
    // Whoever wins hands priority to the other side; idle cycles hold it.
    if (gnt0)      state_d = PRI1;
    else if (gnt1) state_d = PRI0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRI0;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and multi-cycle unit; 1-cycle registered write stage.
// Losers see ready low; dispatch stalls (issue_ready low) while its destination is still pending.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req0_valid,
  input  reg_addr_t req0_rd,
  input  reg_data_t req0_data,
  output logic      req0_ready,
  input  logic      req1_valid,
  input  reg_addr_t req1_rd,
  input  reg_data_t req1_data,
  output logic      req1_ready,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  output logic      issue_ready,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      stall,
  output logic      rf_regwrite,
  output reg_addr_t rf_rd,
  output reg_data_t rf_writedata,
  output logic      err
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                err_q, err_d;
  logic                rf_regwrite_q, rf_regwrite_d;
  reg_addr_t           rf_rd_q, rf_rd_d;
  reg_data_t           rf_writedata_q, rf_writedata_d;
  logic                gnt0, gnt1;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign issue_ready = !pending_q[issue_rd];
  assign stall       = pending_q[rs1] | pending_q[rs2];

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (gnt1) begin
      pending_d[req1_rd] = 1'b0;
      if (!pending_q[req1_rd]) err_d = 1'b1;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    rf_regwrite_d  = 1'b0;
    rf_rd_d        = rf_rd_q;
    rf_writedata_d = rf_writedata_q;
    if (gnt0) begin
      rf_regwrite_d  = (req0_rd != '0);
      rf_rd_d        = req0_rd;
      rf_writedata_d = req0_data;
    end else if (gnt1) begin
      rf_regwrite_d  = (req1_rd != '0);
      rf_rd_d        = req1_rd;
      rf_writedata_d = req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      err_q          <= 1'b0;
      rf_regwrite_q  <= 1'b0;
      rf_rd_q        <= '0;
      rf_writedata_q <= '0;
    end else begin
      pending_q      <= pending_d;
      err_q          <= err_d;
      rf_regwrite_q  <= rf_regwrite_d;
      rf_rd_q        <= rf_rd_d;
      rf_writedata_q <= rf_writedata_d;
    end
  end

  assign rf_regwrite  = rf_regwrite_q;
  assign rf_rd        = rf_rd_q;
  assign rf_writedata = rf_writedata_q;
  assign err          = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed test of the write-back scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      req0_valid, req1_valid, issue_valid;
  reg_addr_t req0_rd, req1_rd, issue_rd, rs1, rs2;
  reg_data_t req0_data, req1_data;
  logic      req0_ready, req1_ready, issue_ready, stall, rf_regwrite, err;
  reg_addr_t rf_rd;
  reg_data_t rf_writedata;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_rd      (req0_rd),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_rd      (req1_rd),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .rs1          (rs1),
    .rs2          (rs2),
    .stall        (stall),
    .rf_regwrite  (rf_regwrite),
    .rf_rd        (rf_rd),
    .rf_writedata (rf_writedata),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    req0_rd = '0; req0_data = '0; req1_rd = '0; req1_data = '0;
    issue_rd = 5'd5; rs1 = '0; rs2 = '0;
    #3;
    chk("rst_regwrite", rf_regwrite, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_writedata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_issue_ready", issue_ready, 1);
    #9 rst_n = 1'b1;
    #1;

    // Continuous contention: expect 3,4,3,4 starting with req0.
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hA;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'hB;
    #1;
    chk("cont_gnt0_first", req0_ready, 1);
    chk("cont_gnt1_first", req1_ready, 0);
    tick();
    chk("cont_rd_0", rf_rd, 3);
    chk("cont_data_0", rf_writedata, 32'hA);
    chk("cont_we_0", rf_regwrite, 1);
    chk("cont_gnt1_second", req1_ready, 1);
    chk("cont_gnt0_second", req0_ready, 0);
    tick();
    chk("cont_rd_1", rf_rd, 4);
    chk("cont_data_1", rf_writedata, 32'hB);
    chk("cont_we_1", rf_regwrite, 1);
    tick();
    chk("cont_rd_2", rf_rd, 3);
    chk("cont_we_2", rf_regwrite, 1);
    tick();
    chk("cont_rd_3", rf_rd, 4);
    chk("cont_we_3", rf_regwrite, 1);
    chk("cont_err_unowed", err, 1);
    idle();
    tick();
    chk("idle_we", rf_regwrite, 0);
    chk("idle_rd_hold", rf_rd, 4);
    chk("idle_data_hold", rf_writedata, 32'hB);

    // Mark rd 6 pending, then reset in the middle of a grant.
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0; rs1 = 5'd6;
    #1;
    chk("pend6_stall", stall, 1);
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'h1010;
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'h1111;
    #1;
    chk("pre_rst_gnt0", req0_ready, 1);
    tick();
    chk("pre_rst_rd", rf_rd, 10);
    chk("pre_rst_gnt1", req1_ready, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", rf_regwrite, 0);
    chk("mid_rst_rd", rf_rd, 0);
    chk("mid_rst_data", rf_writedata, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_stall", stall, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt0", req0_ready, 1);
    chk("post_rst_gnt1", req1_ready, 0);
    tick();
    chk("post_rst_rd", rf_rd, 10);
    chk("post_rst_data", rf_writedata, 32'h1010);
    chk("post_rst_we", rf_regwrite, 1);
    chk("post_rst_err", err, 0);
    idle();

    // x0 write and x0 dispatch.
    rs1 = '0; rs2 = '0;
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_ready", req0_ready, 1);
    chk("x0_issue_ready", issue_ready, 1);
    tick();
    idle();
    chk("x0_we", rf_regwrite, 0);
    chk("x0_data", rf_writedata, 32'hFFFF_FFFF);
    chk("x0_stall", stall, 0);
    chk("x0_issue_ready_after", issue_ready, 1);

    // Scoreboard set on dispatch of rd 7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("iss7_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0; rs1 = 5'd7;
    #1;
    chk("iss7_stall_rs1", stall, 1);
    chk("iss7_busy", issue_ready, 0);
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    chk("iss7_stall_rs2", stall, 1);
    rs2 = 5'd0; rs1 = 5'd7;

    // req1 clears rd 7 while rd 9 is dispatched in the same cycle.
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    chk("clr7_gnt1", req1_ready, 1);
    chk("iss9_ready", issue_ready, 1);
    chk("clr7_stall_pre", stall, 1);
    tick();
    idle();
    chk("clr7_rd", rf_rd, 7);
    chk("clr7_data", rf_writedata, 32'h77);
    chk("clr7_we", rf_regwrite, 1);
    chk("clr7_stall_post", stall, 0);
    chk("clr7_err", err, 0);
    rs1 = 5'd9;
    #1;
    chk("set9_stall", stall, 1);
    issue_rd = 5'd7;
    #1;
    chk("clr7_issue_ready", issue_ready, 1);

    // req1 writes a register that was never issued.
    req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'hC0DE;
    tick();
    idle();
    chk("err12_rd", rf_rd, 12);
    chk("err12_we", rf_regwrite, 1);
    chk("err12_err", err, 1);
    tick();
    chk("err_sticky_we", rf_regwrite, 0);
    chk("err_sticky_1", err, 1);
    tick();
    chk("err_sticky_2", err, 1);
    rst_n = 1'b0;
    #1;
    chk("err_rst", err, 0);
    chk("pend9_rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
